// File: rtl/writeback_stage_if.sv
// Bus between the memory stage, the writeback stage, the register file and the decode bypass.
// The slave modport is the writeback stage; master is whatever drives the memory-stage side.
interface writeback_if #(
  parameter int XLEN = 32
);
  logic            Stall;
  logic            Flush;
  logic            Mem_valid;
  logic            Mem_reg_write;
  logic [4:0]      Mem_rd;
  logic [1:0]      Mem_wb_sel;
  logic [2:0]      Mem_funct3;
  logic [XLEN-1:0] Mem_alu_result;
  logic [XLEN-1:0] Mem_read_data;
  logic [XLEN-1:0] Mem_pc_plus4;
  logic [4:0]      Id_rs1;
  logic [4:0]      Id_rs2;

  logic [4:0]      Write_addr;
  logic            Write_En;
  logic [XLEN-1:0] Write_data;
  logic            Fwd_hit1;
  logic            Fwd_hit2;
  logic [XLEN-1:0] Fwd_data1;
  logic [XLEN-1:0] Fwd_data2;
  logic            Load_fault;
  logic [XLEN-1:0] Instret;

  modport slave (
    input  Stall, Flush, Mem_valid, Mem_reg_write, Mem_rd, Mem_wb_sel, Mem_funct3,
           Mem_alu_result, Mem_read_data, Mem_pc_plus4, Id_rs1, Id_rs2,
    output Write_addr, Write_En, Write_data, Fwd_hit1, Fwd_hit2, Fwd_data1, Fwd_data2,
           Load_fault, Instret
  );

  modport master (
    output Stall, Flush, Mem_valid, Mem_reg_write, Mem_rd, Mem_wb_sel, Mem_funct3,
           Mem_alu_result, Mem_read_data, Mem_pc_plus4, Id_rs1, Id_rs2,
    input  Write_addr, Write_En, Write_data, Fwd_hit1, Fwd_hit2, Fwd_data1, Fwd_data2,
           Load_fault, Instret
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, load extraction/extension, register-file write port,
// same-cycle decode bypass and retired-instruction counter.
module writeback_stage #(
  parameter int          XLEN          = 32,
  // Value Instret takes while in reset; normally zero.
  parameter logic [31:0] INSTRET_RESET = 32'h0
) (
  input logic        Clock,
  input logic        Reset_n,  // active-high despite the name
  writeback_if.slave wb
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    logic [1:0]      wb_sel;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] pc_plus4;
  } wb_entry_t;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  wb_entry_t       entry_d, entry_q;
  logic [XLEN-1:0] instret_d, instret_q;
  logic            incoming_valid;

  assign incoming_valid = wb.Mem_valid & ~wb.Flush;

  always_comb begin
    entry_d   = entry_q;
    instret_d = instret_q;
    if (!wb.Stall) begin
      entry_d.valid      = incoming_valid;
      entry_d.reg_write  = wb.Mem_reg_write;
      entry_d.rd         = wb.Mem_rd;
      entry_d.wb_sel     = wb.Mem_wb_sel;
      entry_d.funct3     = wb.Mem_funct3;
      entry_d.alu_result = wb.Mem_alu_result;
      entry_d.read_data  = wb.Mem_read_data;
      entry_d.pc_plus4   = wb.Mem_pc_plus4;
      instret_d          = instret_q + XLEN'(incoming_valid);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset_n) begin
    if (Reset_n) begin
      entry_q   <= '0;
      instret_q <= INSTRET_RESET;
    end else begin
      entry_q   <= entry_d;
      instret_q <= instret_d;
    end
  end

  logic [1:0]      off;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_val;
  logic            bad_load;
  logic            load_fault;
  logic            write_en;
  logic [XLEN-1:0] write_data;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    off      = entry_q.alu_result[1:0];
    lane_b   = 8'(entry_q.read_data >> {off, 3'b000});
    lane_h   = off[1] ? entry_q.read_data[31:16] : entry_q.read_data[15:0];
    load_val = entry_q.read_data;
    bad_load = 1'b0;
    case (entry_q.funct3)
      3'b000:  load_val = {{(XLEN-8){lane_b[7]}}, lane_b};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, lane_b};
      3'b001: begin
        load_val = {{(XLEN-16){lane_h[15]}}, lane_h};
        bad_load = off[0];
      end
      3'b101: begin
        load_val = {{(XLEN-16){1'b0}}, lane_h};
        bad_load = off[0];
      end
      3'b010:  bad_load = (off != 2'b00);
      default: bad_load = 1'b1;
    endcase

    load_fault = entry_q.valid & (entry_q.wb_sel == SEL_LOAD) & bad_load;
    write_en   = entry_q.valid & entry_q.reg_write & (entry_q.rd != 5'd0) & ~load_fault;

    // Reserved selector 11 falls through to the ALU result.
    if (load_fault)                        write_data = '0;
    else if (entry_q.wb_sel == SEL_LOAD)   write_data = load_val;
    else if (entry_q.wb_sel == SEL_LINK)   write_data = entry_q.pc_plus4;
    else                                   write_data = entry_q.alu_result;
  end

  assign wb.Write_addr = entry_q.rd;
  assign wb.Write_En   = write_en;
  assign wb.Write_data = write_data;
  assign wb.Load_fault = load_fault;
  assign wb.Instret    = instret_q;

  // rd=0 never reaches here as a hit because write_en already excludes it.
  assign wb.Fwd_hit1  = write_en & (wb.Id_rs1 == entry_q.rd);
  assign wb.Fwd_hit2  = write_en & (wb.Id_rs2 == entry_q.rd);
  assign wb.Fwd_data1 = write_data;
  assign wb.Fwd_data2 = write_data;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised and directed bench for writeback_stage against a behavioural model.
// A second instance with a preset retired counter exercises the wrap to zero.
module tb_writeback_stage;

  localparam logic [31:0] WRAP_INIT = 32'hFFFF_FFFF;

  logic Clock = 1'b0;
  logic Reset_n;

  writeback_if #(.XLEN(32)) bus ();
  writeback_if #(.XLEN(32)) bus2 ();

  writeback_stage #(.XLEN(32)) dut (.Clock(Clock), .Reset_n(Reset_n), .wb(bus));
  writeback_stage #(.XLEN(32), .INSTRET_RESET(WRAP_INIT)) dut_wrap (
    .Clock(Clock), .Reset_n(Reset_n), .wb(bus2));

  assign bus2.Stall          = bus.Stall;
  assign bus2.Flush          = bus.Flush;
  assign bus2.Mem_valid      = bus.Mem_valid;
  assign bus2.Mem_reg_write  = bus.Mem_reg_write;
  assign bus2.Mem_rd         = bus.Mem_rd;
  assign bus2.Mem_wb_sel     = bus.Mem_wb_sel;
  assign bus2.Mem_funct3     = bus.Mem_funct3;
  assign bus2.Mem_alu_result = bus.Mem_alu_result;
  assign bus2.Mem_read_data  = bus.Mem_read_data;
  assign bus2.Mem_pc_plus4   = bus.Mem_pc_plus4;
  assign bus2.Id_rs1         = bus.Id_rs1;
  assign bus2.Id_rs2         = bus.Id_rs2;

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 0, m_rw = 0;
  logic [4:0]  m_rd = 0;
  logic [1:0]  m_sel = 0;
  logic [2:0]  m_f3 = 0;
  logic [31:0] m_alu = 0, m_data = 0, m_pc = 0;
  longint      m_retired = 0;

  always @(posedge Clock or posedge Reset_n) begin
    if (Reset_n) begin
      m_valid <= 0; m_rw <= 0; m_rd <= 0; m_sel <= 0; m_f3 <= 0;
      m_alu <= 0; m_data <= 0; m_pc <= 0; m_retired <= 0;
    end else if (!bus.Stall) begin
      m_valid <= bus.Mem_valid && !bus.Flush;
      m_rw    <= bus.Mem_reg_write;
      m_rd    <= bus.Mem_rd;
      m_sel   <= bus.Mem_wb_sel;
      m_f3    <= bus.Mem_funct3;
      m_alu   <= bus.Mem_alu_result;
      m_data  <= bus.Mem_read_data;
      m_pc    <= bus.Mem_pc_plus4;
      if (bus.Mem_valid && !bus.Flush) m_retired <= m_retired + 1;
    end
  end

  function automatic int unsigned access_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;  // illegal
    endcase
  endfunction

  function automatic bit exp_bad(input logic [2:0] f3, input int unsigned off);
    int unsigned sz = access_size(f3);
    if (sz == 0) return 1;
    return (off % sz) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input int unsigned off,
                                           input logic [31:0] data);
    longint unsigned b = (longint'(data) >> (8 * off)) & 255;
    longint unsigned h = (longint'(data) >> (16 * (off / 2))) & 65535;
    case (f3)
      3'b000:  return 32'((b >= 128) ? longint'(b) - 256 : longint'(b));
      3'b100:  return 32'(b);
      3'b001:  return 32'((h >= 32768) ? longint'(h) - 65536 : longint'(h));
      3'b101:  return 32'(h);
      default: return data;
    endcase
  endfunction

  function automatic bit exp_fault();
    return m_valid && m_sel == 2'b01 && exp_bad(m_f3, int'(m_alu % 4));
  endfunction

  function automatic bit exp_we();
    return m_valid && m_rw && m_rd != 0 && !exp_fault();
  endfunction

  function automatic logic [31:0] exp_wd();
    if (exp_fault()) return 32'h0;
    case (m_sel)
      2'b01:   return exp_load(m_f3, int'(m_alu % 4), m_data);
      2'b10:   return m_pc;
      default: return m_alu;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always begin
    @(posedge Clock);
    #3;
    check("write_addr", 32'(bus.Write_addr), 32'(m_rd));
    check("write_en",   32'(bus.Write_En),   32'(exp_we()));
    check("write_data", bus.Write_data,      exp_wd());
    check("load_fault", 32'(bus.Load_fault), 32'(exp_fault()));
    check("fwd_hit1",   32'(bus.Fwd_hit1),   32'(exp_we() && bus.Id_rs1 == m_rd));
    check("fwd_hit2",   32'(bus.Fwd_hit2),   32'(exp_we() && bus.Id_rs2 == m_rd));
    check("fwd_data1",  bus.Fwd_data1,       exp_wd());
    check("fwd_data2",  bus.Fwd_data2,       exp_wd());
    check("instret",    bus.Instret,         32'(m_retired));
    check("instret_wrap", bus2.Instret,      32'(longint'(WRAP_INIT) + m_retired));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [31:0] pc, input logic stall, input logic flush);
    bus.Mem_valid = v;       bus.Mem_reg_write = rw;  bus.Mem_rd = rd;
    bus.Mem_wb_sel = sel;    bus.Mem_funct3 = f3;     bus.Mem_alu_result = alu;
    bus.Mem_read_data = rdat; bus.Mem_pc_plus4 = pc;
    bus.Stall = stall;       bus.Flush = flush;
  endtask

  task automatic tick();
    @(posedge Clock);
    #4;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t loads [5];
  logic [31:0] rnd;

  initial begin
    loads[0] = '{3'b000, 32'h0000_0003, 32'hFFFF_FF80};  // LB  off 3
    loads[1] = '{3'b100, 32'h0000_0001, 32'h0000_007F};  // LBU off 1
    loads[2] = '{3'b001, 32'h0000_0002, 32'hFFFF_80FF};  // LH  off 2
    loads[3] = '{3'b101, 32'h0000_0000, 32'h0000_7F01};  // LHU off 0
    loads[4] = '{3'b010, 32'h0000_0100, 32'h80FF_7F01};  // LW  off 0

    Reset_n = 1'b1;
    bus.Id_rs1 = 0;
    bus.Id_rs2 = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("rst_write_en",   32'(bus.Write_En),   32'h0);
    check("rst_write_addr", 32'(bus.Write_addr), 32'h0);
    check("rst_write_data", bus.Write_data,      32'h0);
    check("rst_instret",    bus.Instret,         32'h0);
    check("rst_load_fault", 32'(bus.Load_fault), 32'h0);
    Reset_n = 1'b0;

    // ALU writeback
    drive(1, 1, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 0, 0);
    tick();
    check("alu_we",   32'(bus.Write_En),   32'h1);
    check("alu_addr", 32'(bus.Write_addr), 32'h5);
    check("alu_data", bus.Write_data,      32'h1234);
    check("alu_instret", bus.Instret,      32'h1);
    check("wrap_to_zero", bus2.Instret,    32'h0);

    foreach (loads[i]) begin
      drive(1, 1, 5'd7, 2'b01, loads[i].f3, loads[i].alu, 32'h80FF_7F01, 32'h0, 0, 0);
      tick();
      check("load_data", bus.Write_data, loads[i].exp);
      check("load_we",   32'(bus.Write_En), 32'h1);
    end
    check("loads_instret", bus.Instret, 32'd6);

    // misaligned LW
    drive(1, 1, 5'd7, 2'b01, 3'b010, 32'h2, 32'h80FF_7F01, 32'h0, 0, 0);
    tick();
    check("lw_mis_fault", 32'(bus.Load_fault), 32'h1);
    check("lw_mis_we",    32'(bus.Write_En),   32'h0);
    check("lw_mis_data",  bus.Write_data,      32'h0);
    check("lw_mis_instret", bus.Instret,       32'd7);

    // illegal funct3
    drive(1, 1, 5'd7, 2'b01, 3'b011, 32'h0, 32'h80FF_7F01, 32'h0, 0, 0);
    tick();
    check("f3_011_fault", 32'(bus.Load_fault), 32'h1);
    check("f3_011_we",    32'(bus.Write_En),   32'h0);
    check("f3_011_instret", bus.Instret,       32'd8);

    // rd = 0
    drive(1, 1, 5'd0, 2'b00, 3'b000, 32'h7, 32'h0, 32'h0, 0, 0);
    tick();
    check("rd0_we",    32'(bus.Write_En),   32'h0);
    check("rd0_fault", 32'(bus.Load_fault), 32'h0);

    // bypass + stall + flush
    bus.Id_rs1 = 5'd9;
    bus.Id_rs2 = 5'd0;
    drive(1, 1, 5'd9, 2'b00, 3'b000, 32'hCAFE, 32'h0, 32'h0, 0, 0);
    tick();
    check("byp_hit1",  32'(bus.Fwd_hit1), 32'h1);
    check("byp_data1", bus.Fwd_data1,     32'hCAFE);
    check("byp_hit2",  32'(bus.Fwd_hit2), 32'h0);
    check("byp_instret", bus.Instret,     32'd10);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'd3, 2'b10, 3'b000, $urandom, $urandom, $urandom, 1, 0);
      tick();
      check("stall_we",   32'(bus.Write_En),   32'h1);
      check("stall_addr", 32'(bus.Write_addr), 32'h9);
      check("stall_data", bus.Write_data,      32'hCAFE);
      check("stall_instret", bus.Instret,      32'd10);
    end
    drive(1, 1, 5'd3, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 1, 1);
    tick();
    check("stall_flush_we",   32'(bus.Write_En), 32'h1);
    check("stall_flush_data", bus.Write_data,    32'hCAFE);
    drive(1, 1, 5'd3, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 0, 1);
    tick();
    check("flush_we",      32'(bus.Write_En), 32'h0);
    check("flush_instret", bus.Instret,       32'd10);

    // async reset in the middle of a stall
    bus.Id_rs1 = 5'd4;
    drive(1, 1, 5'd4, 2'b00, 3'b000, 32'hBEEF, 32'h0, 32'h0, 0, 0);
    tick();
    check("pre_rst_instret", bus.Instret, 32'd11);
    bus.Stall = 1'b1;
    tick();
    #2 Reset_n = 1'b1;
    #1;
    check("mid_rst_we",      32'(bus.Write_En),   32'h0);
    check("mid_rst_addr",    32'(bus.Write_addr), 32'h0);
    check("mid_rst_data",    bus.Write_data,      32'h0);
    check("mid_rst_hit1",    32'(bus.Fwd_hit1),   32'h0);
    check("mid_rst_fault",   32'(bus.Load_fault), 32'h0);
    check("mid_rst_instret", bus.Instret,         32'h0);
    tick();
    Reset_n = 1'b0;

    // randomised traffic
    for (int c = 0; c < 400; c++) begin
      rnd = $urandom;
      drive(rnd[2:0] != 3'd0, rnd[4:3] != 2'd0,
            (rnd[6:5] == 2'd0) ? 5'd0 : 5'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, rnd[9:8] == 2'd0, rnd[12:10] == 3'd0);
      bus.Id_rs1 = rnd[13] ? m_rd : 5'($urandom);
      bus.Id_rs2 = rnd[14] ? m_rd : 5'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
